// File: rtl/text_cell_scheduler.sv
// text_cell_scheduler: walks one text row of the character buffer, fetching
// cell words {char, fg, bg} into a 2-entry prefetch buffer that feeds the
// 8x8 glyph blender one pixel per enabled clock.
// Optional build macro CURSOR_BLINK_EN adds a blinking cursor (fg/bg swap).
//
// state | meaning
// IDLE  | no line in progress, or line fully fetched and drained
// FETCH | issue one RAM read at row_base+fetch_col (stalls while a read is outstanding)
// WAIT  | read in flight, waiting for its data to land in the buffer
// HOLD  | buffer full or whole row fetched; waiting for a free slot / drain
module text_cell_scheduler #(
  parameter int COLS      = 80,
  parameter int ROWS      = 60,
  parameter int ADDR_W    = 13,
  parameter int BASE_ADDR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_line_start,
  input  logic [9:0]        i_line_y,
  input  logic              i_pixel_en,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_rd,
  input  logic [31:0]       i_ram_data,
  input  logic              i_ram_valid,
  output logic [7:0]        o_char,
  output logic [2:0]        o_row,
  output logic [2:0]        o_column,
  output logic [11:0]       o_fg_color,
  output logic [11:0]       o_bg_color,
  output logic              o_pixel_valid,
  output logic              o_underrun,
  input  logic              i_clear_underrun
`ifdef CURSOR_BLINK_EN
  ,
  input  logic [6:0]        i_cursor_col,
  input  logic [5:0]        i_cursor_row,
  input  logic              i_frame_start
`endif
);

  localparam int            CW     = $clog2(COLS + 1);
  localparam logic [CW-1:0] COLS_L = CW'(COLS);
  localparam logic [6:0]    ROWS_L = 7'(ROWS);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     fetch_col_q, fetch_col_d;
  logic [CW-1:0]     disp_col_q, disp_col_d;
  logic [2:0]        column_q, column_d;
  logic [2:0]        row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              line_active_q, line_active_d;
  logic [31:0]       buf_q [2];
  logic [31:0]       buf_d [2];
  logic              head_q, head_d;
  logic [1:0]        count_q, count_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              out_q, out_d;      // a read is outstanding at the RAM
  logic              drop_q, drop_d;    // the outstanding read belongs to a dead line
  logic              underrun_q, underrun_d;
`ifdef CURSOR_BLINK_EN
  logic [6:0]        text_row_q, text_row_d;
  logic [4:0]        frame_q, frame_d;
`endif

  logic [6:0]        text_row_new;
  logic              pending_rd;
  logic              push, pop, advance;
  logic [31:0]       head_w;
  logic              cell_valid, swap;

  assign text_row_new = (i_line_y[9:3] >= ROWS_L) ? 7'd0 : i_line_y[9:3];
  assign o_ram_rd     = (state_q == S_FETCH) && !out_q;
  assign o_ram_addr   = row_base_q + ADDR_W'(fetch_col_q);
  // A read issued now, or one still waiting for its data, must be ignored
  // when it returns after a line restart or reset.
  assign pending_rd   = o_ram_rd || (out_q && !i_ram_valid);
  assign head_w       = buf_q[head_q];
  assign cell_valid   = line_active_q && (count_q != 2'd0);
  assign advance      = i_pixel_en && line_active_q;
  assign pop          = advance && (count_q != 2'd0) && (column_q == 3'd7);
  assign push         = rvalid_q;

`ifdef CURSOR_BLINK_EN
  assign swap = frame_q[4] && (32'(disp_col_q) == 32'(i_cursor_col)) &&
                (text_row_q == {1'b0, i_cursor_row});
`else
  assign swap = 1'b0;
`endif

  // Next-state: fetch FSM, prefetch buffer, pixel walk, drop tracking
  always_comb begin
    state_d       = state_q;
    fetch_col_d   = fetch_col_q;
    disp_col_d    = disp_col_q;
    column_d      = column_q;
    row_d         = row_q;
    row_base_d    = row_base_q;
    line_active_d = line_active_q;
    buf_d         = buf_q;
    head_d        = head_q;
    count_d       = count_q;
    rdata_d       = i_ram_data;
    rvalid_d      = i_ram_valid && !drop_q;
    out_d         = o_ram_rd ? 1'b1 : (i_ram_valid ? 1'b0 : out_q);
    drop_d        = i_ram_valid ? 1'b0 : drop_q;
    underrun_d    = (advance && (count_q == 2'd0)) ? 1'b1
                  : (i_clear_underrun ? 1'b0 : underrun_q);
`ifdef CURSOR_BLINK_EN
    text_row_d    = text_row_q;
    frame_d       = i_frame_start ? frame_q + 5'd1 : frame_q;
`endif

    if (push) buf_d[head_q ^ count_q[0]] = rdata_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (pop) head_d = ~head_q;

    if (advance) column_d = column_q + 3'd1;
    if (pop) begin
      disp_col_d = disp_col_q + CW'(1);
      if (disp_col_q == COLS_L - CW'(1)) line_active_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: ;
      S_FETCH: begin
        if (o_ram_rd) begin
          fetch_col_d = fetch_col_q + CW'(1);
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (push) begin
          if ((count_d < 2'd2) && (fetch_col_q < COLS_L)) state_d = S_FETCH;
          else                                            state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if ((fetch_col_q < COLS_L) && (count_q < 2'd2))        state_d = S_FETCH;
        else if ((fetch_col_q == COLS_L) && (count_q == 2'd0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (i_line_start) begin
      state_d       = S_FETCH;
      fetch_col_d   = '0;
      disp_col_d    = '0;
      column_d      = '0;
      row_d         = i_line_y[2:0];
      row_base_d    = ADDR_W'(BASE_ADDR) + ADDR_W'(32'(text_row_new) * COLS);
      line_active_d = 1'b1;
      head_d        = 1'b0;
      count_d       = 2'd0;
      rvalid_d      = 1'b0;
      out_d         = pending_rd;
      drop_d        = pending_rd;
`ifdef CURSOR_BLINK_EN
      text_row_d    = text_row_new;
`endif
    end
  end

  // State registers; reset keeps track of a read still owed by the RAM
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      fetch_col_q   <= '0;
      disp_col_q    <= '0;
      column_q      <= '0;
      row_q         <= '0;
      row_base_q    <= '0;
      line_active_q <= 1'b0;
      buf_q         <= '{default: '0};
      head_q        <= 1'b0;
      count_q       <= 2'd0;
      rdata_q       <= '0;
      rvalid_q      <= 1'b0;
      out_q         <= pending_rd;
      drop_q        <= pending_rd;
      underrun_q    <= 1'b0;
`ifdef CURSOR_BLINK_EN
      text_row_q    <= '0;
      frame_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_col_q   <= fetch_col_d;
      disp_col_q    <= disp_col_d;
      column_q      <= column_d;
      row_q         <= row_d;
      row_base_q    <= row_base_d;
      line_active_q <= line_active_d;
      buf_q         <= buf_d;
      head_q        <= head_d;
      count_q       <= count_d;
      rdata_q       <= rdata_d;
      rvalid_q      <= rvalid_d;
      out_q         <= out_d;
      drop_q        <= drop_d;
      underrun_q    <= underrun_d;
`ifdef CURSOR_BLINK_EN
      text_row_q    <= text_row_d;
      frame_q       <= frame_d;
`endif
    end
  end

  // Cell outputs: blank when no cell is held, optional cursor color swap
  always_comb begin
    o_char     = '0;
    o_fg_color = '0;
    o_bg_color = '0;
    if (cell_valid) begin
      o_char = head_w[31:24];
      if (swap) begin
        o_fg_color = head_w[11:0];
        o_bg_color = head_w[23:12];
      end else begin
        o_fg_color = head_w[23:12];
        o_bg_color = head_w[11:0];
      end
    end
  end

  assign o_row         = row_q;
  assign o_column      = column_q;
  assign o_pixel_valid = cell_valid;
  assign o_underrun    = underrun_q;

endmodule
